draw_cmd: RTL and testbench

- Sequences CHIP-8 DXYN (sprite draw) and 00E0 (clear screen) instructions from the CPU execute stage into the draw engine.
- Latches the operands, translates them into the draw engine's en/cls_en/I/start_pix/start_nibbles command, and tracks the engine's busy signal.
- Accumulates the engine's collision output, then returns a VF writeback and a done handshake to the CPU.
- Sits directly upstream of draw, between the CPU and draw.

---
 rtl/draw_cmd.sv | 173 +++++++++++++++++
 tb/tb_draw_cmd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd.sv
`default_nettype none
// ============================================================================
// Module      : draw_cmd
// Description : Sequences CHIP-8 DXYN / 00E0 instructions from the CPU into
//               the draw engine, accumulates sprite collision and returns a
//               VF writeback plus a done handshake.
// Revision    : 1.0
// ============================================================================
module draw_cmd #(
  parameter int ARM_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int CLS_CYCLES   = 2050
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        cls_req,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [15:0] i_reg,
  output logic        done,
  output logic        vf_we,
  output logic [7:0]  vf_d,
  output logic        active,
  output logic        draw_en,
  output logic        draw_cls_en,
  output logic [15:0] draw_I,
  output logic [10:0] draw_start_pix,
  output logic [3:0]  draw_nibbles,
  input  logic        draw_busy,
  input  logic        draw_col
);

  // Counter is sized for the longest of the three wait phases.
  localparam int MAX_A   = (ARM_CYCLES > DRAIN_CYCLES) ? ARM_CYCLES : DRAIN_CYCLES;
  localparam int MAX_CYC = (MAX_A > CLS_CYCLES) ? MAX_A : CLS_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    ARM      = 3'd2,
    WAIT     = 3'd3,
    DRAIN    = 3'd4,
    CLS_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             collision;

  // Upper coordinate bits are discarded: the screen wraps modulo 64x32.
  logic unused_coord_bits;
  assign unused_coord_bits = &{1'b0, vx[7:6], vy[7:5]};

  // Active is a pure decode of the state register.
  assign active = (state != IDLE);

  // Command sequencer: operand latch, engine pulses, collision accumulation
  // and the completion handshake, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      collision      <= 1'b0;
      done           <= 1'b0;
      vf_we          <= 1'b0;
      vf_d           <= 8'h00;
      draw_en        <= 1'b0;
      draw_cls_en    <= 1'b0;
      draw_I         <= 16'h0000;
      draw_start_pix <= 11'h000;
      draw_nibbles   <= 4'h0;
    end else begin
      // Pulses default low; each is raised only on the transition into the
      // state where it must be seen.
      draw_en     <= 1'b0;
      draw_cls_en <= 1'b0;
      done        <= 1'b0;
      vf_we       <= 1'b0;
      vf_d        <= 8'h00;

      case (state)
        IDLE: begin
          if (cls_req) begin
            // Clear wins over a simultaneous draw; the draw is picked up
            // after the clear's done because req stays held.
            draw_cls_en <= 1'b1;
            cnt         <= CNT_W'(CLS_CYCLES - 1);
            state       <= CLS_WAIT;
          end else if (req) begin
            if (n == 4'h0) begin
              // Zero-height sprite: nothing to draw, report no collision.
              collision <= 1'b0;
              done      <= 1'b1;
              vf_we     <= 1'b1;
              state     <= DONE;
            end else begin
              // Operands are latched here so they are valid alongside the
              // draw_en pulse and held until the next issue.
              draw_en        <= 1'b1;
              draw_I         <= i_reg;
              draw_start_pix <= {vy[4:0], vx[5:0]};
              draw_nibbles   <= n;
              state          <= ISSUE;
            end
          end
        end

        ISSUE: begin
          collision <= 1'b0;
          cnt       <= CNT_W'(ARM_CYCLES - 1);
          state     <= ARM;
        end

        ARM: begin
          // Busy from the engine is not yet valid here.
          collision <= collision | draw_col;
          if (cnt == '0) begin
            state <= WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WAIT: begin
          // Busy may be stretched by vsync; wait as long as it takes.
          collision <= collision | draw_col;
          if (!draw_busy) begin
            cnt   <= CNT_W'(DRAIN_CYCLES - 1);
            state <= DRAIN;
          end
        end

        DRAIN: begin
          // col lags busy through the engine pipeline and self-clears, so
          // keep sampling it and make the result sticky.
          collision <= collision | draw_col;
          if (cnt == '0) begin
            done  <= 1'b1;
            vf_we <= 1'b1;
            vf_d  <= {7'b0, collision | draw_col};
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        CLS_WAIT: begin
          // The engine's busy does not cover clears, so time it out.
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_cmd
// Description : Self-checking bench for draw_cmd using a cycle-timeline model.
// Revision    : 1.0
// ============================================================================
module tb_draw_cmd;
  localparam int ARM   = 2;
  localparam int DRAIN = 2;
  localparam int CLS   = 2050;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        cls_req = 1'b0;
  logic [7:0]  vx = 8'h00;
  logic [7:0]  vy = 8'h00;
  logic [3:0]  n = 4'h0;
  logic [15:0] i_reg = 16'h0000;
  logic        draw_busy = 1'b0;
  logic        draw_col = 1'b0;
  logic        done, vf_we, active, draw_en, draw_cls_en;
  logic [7:0]  vf_d;
  logic [15:0] draw_I;
  logic [10:0] draw_start_pix;
  logic [3:0]  draw_nibbles;

  draw_cmd #(.ARM_CYCLES(ARM), .DRAIN_CYCLES(DRAIN), .CLS_CYCLES(CLS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cls_req(cls_req),
    .vx(vx), .vy(vy), .n(n), .i_reg(i_reg),
    .done(done), .vf_we(vf_we), .vf_d(vf_d), .active(active),
    .draw_en(draw_en), .draw_cls_en(draw_cls_en), .draw_I(draw_I),
    .draw_start_pix(draw_start_pix), .draw_nibbles(draw_nibbles),
    .draw_busy(draw_busy), .draw_col(draw_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int both_pulse = 0;

  // Both engine pulses in one cycle is never legal.
  always @(negedge clk) if (draw_en && draw_cls_en) both_pulse++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one draw whose request is seen by the block in cycle t0 (the
  // current cycle). busy is high for offsets 1..blen after the issue cycle,
  // col is high for offsets coff..coff+clen-1.
  task automatic do_draw(input string tag, input int t0, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] nn, input logic [15:0] ii,
                         input int blen, input int coff, input int clen);
    int issue, twait, c, exp_done, en_cnt, en_cyc, done_cyc, cls_cnt, stray_vf, inactive, off;
    logic exp_col;
    logic [10:0] exp_pix;
    logic vfwe_at;
    logic [7:0] vfd_at;
    issue    = t0 + 1;
    twait    = issue + 1 + ARM;
    c        = (twait > issue + blen + 1) ? twait : issue + blen + 1;
    exp_done = (nn == 4'h0) ? t0 + 1 : c + DRAIN + 1;
    exp_col  = (nn != 4'h0) && (clen > 0) && (coff <= c + DRAIN - issue) && (coff + clen - 1 >= 1);
    exp_pix  = 11'((int'(y) % 32) * 64 + (int'(x) % 64));
    en_cnt = 0; en_cyc = -1; done_cyc = -1; cls_cnt = 0; stray_vf = 0; inactive = 0;
    vfwe_at = 1'b0; vfd_at = 8'h00;
    vx = x; vy = y; n = nn; i_reg = ii; req = 1'b1;
    draw_busy = 1'b0; draw_col = 1'b0;
    while (done_cyc < 0 && cyc < exp_done + 20) begin
      tick();
      off = cyc - issue;
      draw_busy = (nn != 4'h0) && (off >= 1) && (off <= blen);
      draw_col  = (clen > 0) && (off >= coff) && (off < coff + clen);
      if (!active) inactive++;
      if (draw_cls_en) cls_cnt++;
      if (vf_we && !done) stray_vf++;
      if (draw_en) begin
        en_cnt++;
        en_cyc = cyc;
        check({tag, ".pix"}, 32'(draw_start_pix), 32'(exp_pix));
        check({tag, ".nib"}, 32'(draw_nibbles), 32'(nn));
        check({tag, ".I"}, 32'(draw_I), 32'(ii));
      end
      if (done) begin
        done_cyc = cyc;
        vfwe_at  = vf_we;
        vfd_at   = vf_d;
        req      = 1'b0;
      end
    end
    check({tag, ".done_cyc"}, 32'(done_cyc - t0), 32'(exp_done - t0));
    check({tag, ".vf_we"}, 32'(vfwe_at), 32'd1);
    check({tag, ".vf_d"}, 32'(vfd_at), 32'(exp_col));
    check({tag, ".en_cnt"}, 32'(en_cnt), (nn != 4'h0) ? 32'd1 : 32'd0);
    if (nn != 4'h0) check({tag, ".en_cyc"}, 32'(en_cyc - t0), 32'd1);
    check({tag, ".no_cls"}, 32'(cls_cnt), 32'd0);
    check({tag, ".stray_vf"}, 32'(stray_vf), 32'd0);
    check({tag, ".active"}, 32'(inactive), 32'd0);
    if (nn != 4'h0) check({tag, ".hold_pix"}, 32'(draw_start_pix), 32'(exp_pix));
    draw_busy = 1'b0;
    draw_col  = 1'b0;
    tick();
    check({tag, ".post_idle"}, {30'd0, active, done}, 32'd0);
  endtask

  initial begin
    int t0, done_cyc, cls_cyc, cls_cnt, en_cnt, bad;
    logic [7:0] rx, ry;
    logic [3:0] rn;
    logic [15:0] ri;

    // Reset state
    tick();
    tick();
    check("rst.outs", {22'd0, done, vf_we, active, draw_en, draw_cls_en, 5'd0}, 32'd0);
    check("rst.bus", {1'b0, draw_start_pix, draw_nibbles, draw_I}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic draw
    do_draw("basic", cyc, 8'd10, 8'd5, 4'd5, 16'h0050, 40, -1, 0);
    // Wrap plus mid-WAIT collision pulse
    do_draw("wrap", cyc, 8'd70, 8'd33, 4'd3, 16'h0200, 30, 15, 1);
    // Collision one cycle after busy falls (captured in DRAIN)
    do_draw("late_col", cyc, 8'd1, 8'd2, 4'd4, 16'h0300, 10, 12, 1);
    // Collision just past the drain window (must be ignored)
    do_draw("past_col", cyc, 8'd1, 8'd2, 4'd4, 16'h0300, 10, 14, 2);
    // Busy stretched by vsync
    do_draw("late_frame", cyc, 8'd63, 8'd31, 4'd15, 16'h0FFF, 500, -1, 0);
    // Zero-height sprite
    do_draw("n0", cyc, 8'd20, 8'd20, 4'd0, 16'h0123, 0, 0, 3);

    // Clear priority over a simultaneous draw
    t0 = cyc;
    req = 1'b1; cls_req = 1'b1;
    vx = 8'd12; vy = 8'd7; n = 4'd2; i_reg = 16'h0400;
    done_cyc = -1; cls_cyc = -1; cls_cnt = 0; en_cnt = 0; bad = 0;
    while (done_cyc < 0 && cyc < t0 + CLS + 20) begin
      tick();
      if (draw_cls_en) begin cls_cnt++; cls_cyc = cyc; end
      if (draw_en) en_cnt++;
      if (done) begin
        done_cyc = cyc;
        if (vf_we) bad++;
        cls_req = 1'b0;
      end
    end
    check("cls.pulse_cnt", 32'(cls_cnt), 32'd1);
    check("cls.pulse_cyc", 32'(cls_cyc - t0), 32'd1);
    check("cls.done_cyc", 32'(done_cyc - t0), 32'(CLS + 1));
    check("cls.vf_we", 32'(bad), 32'd0);
    check("cls.no_en", 32'(en_cnt), 32'd0);
    tick();
    do_draw("after_cls", cyc, 8'd12, 8'd7, 4'd2, 16'h0400, 5, 3, 1);

    // Randomized draws against the timeline model
    for (int k = 0; k < 12; k++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rn = 4'($urandom_range(0, 15));
      ri = 16'($urandom);
      do_draw("rand", cyc, rx, ry, rn, ri, int'($urandom_range(0, 25)),
              int'($urandom_range(0, 35)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of WAIT
    req = 1'b1; vx = 8'd3; vy = 8'd4; n = 4'd6; i_reg = 16'h0777; draw_busy = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("rstw.active_before", 32'(active), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw.outs", {22'd0, done, vf_we, active, draw_en, draw_cls_en, 5'd0}, 32'd0);
    check("rstw.bus", {1'b0, draw_start_pix, draw_nibbles, draw_I}, 32'd0);
    check("rstw.vf_d", 32'(vf_d), 32'd0);
    req = 1'b0; draw_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || active || vf_we || draw_en || draw_cls_en) bad++;
    end
    check("rstw.quiet", 32'(bad), 32'd0);
    check("pulse_overlap", 32'(both_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
